// File: rtl/blank_slot_scheduler_if.sv
// Bundle of video-timing inputs, requester handshake and strobe outputs
// shared between the blank-slot scheduler and its environment.
interface blank_slot_scheduler_if #(
  parameter int NREQ = 4
);
  logic [9:0]      hpos;
  logic [9:0]      vpos;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] grant;
  logic [2:0]      grant_id;
  logic            busy;
  logic            abort;
  logic            line_start;
  logic            frame_start;
  logic [7:0]      frame_cnt;

  modport slave (
    input  hpos, vpos, req, done,
    output grant, grant_id, busy, abort, line_start, frame_start, frame_cnt
  );

  modport master (
    output hpos, vpos, req, done,
    input  grant, grant_id, busy, abort, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/blank_slot_scheduler.sv
// Round-robin arbiter for one shared compute slot; grants only inside the
// blanking window, plus line/frame strobes and a wrapping frame counter.
module blank_slot_scheduler #(
  parameter int NREQ      = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_MAX     = 799,
  parameter int V_DISPLAY = 480,
  parameter int V_MAX     = 524,
  parameter int GUARD     = 8,
  parameter int MAX_JOB   = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  blank_slot_scheduler_if.slave bus
);
  localparam int CW = (MAX_JOB > 2) ? $clog2(MAX_JOB) : 1;
  localparam logic [9:0]      H_DISP_C   = 10'(H_DISPLAY);
  localparam logic [9:0]      H_MAX_C    = 10'(H_MAX);
  localparam logic [9:0]      H_LAST_C   = 10'(H_MAX - GUARD);
  localparam logic [9:0]      V_DISP_C   = 10'(V_DISPLAY);
  localparam logic [9:0]      V_MAX_C    = 10'(V_MAX);
  localparam logic [CW-1:0]   JOB_LAST_C = CW'(MAX_JOB - 1);
  localparam logic [2:0]      LAST_ID_C  = 3'(NREQ - 1);
  localparam logic [3:0]      NREQ_C     = 4'(NREQ);
  localparam logic [NREQ-1:0] ONE_C      = NREQ'(1);

  typedef enum logic [1:0] {ST_CLOSED = 2'd0, ST_ARB = 2'd1, ST_BUSY = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [NREQ-1:0] grant_r, grant_s;
  logic [2:0]      grant_id_r, grant_id_s;
  logic            busy_r, busy_s;
  logic            abort_r, abort_s;
  logic [2:0]      rr_r, rr_s;
  logic [NREQ-1:0] sticky_r, sticky_s;
  logic [2:0]      sticky_id_r, sticky_id_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            line_start_r, frame_start_r;
  logic [7:0]      frame_cnt_r;

  logic            win_open_s, any_req_s, release_s, found_s;
  logic [NREQ-1:0] rot_s;
  logic [3:0]      offs_s, sum_s;
  logic [2:0]      scan_id_s, win_id_s, next_id_s;

  assign win_open_s = ((bus.vpos >= V_DISP_C) || (bus.hpos >= H_DISP_C)) && (bus.hpos <= H_LAST_C);
  assign any_req_s  = |bus.req;
  // A grant ends normally on the grantee's own done or when it drops req.
  assign release_s  = (|(grant_r & bus.done)) || !(|(grant_r & bus.req));
  assign next_id_s  = (grant_id_r == LAST_ID_C) ? 3'd0 : grant_id_r + 3'd1;

  // Winner: a sticky (window-aborted) requester first, else rotating scan from rr.
  always_comb begin
    rot_s   = NREQ'({bus.req, bus.req} >> rr_r);
    found_s = 1'b0;
    offs_s  = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        offs_s  = 4'(k);
      end else begin
        offs_s  = offs_s;
      end
    end
    sum_s = {1'b0, rr_r} + offs_s;
    if (sum_s >= NREQ_C) begin
      scan_id_s = 3'(sum_s - NREQ_C);
    end else begin
      scan_id_s = 3'(sum_s);
    end
    if (|(sticky_r & bus.req)) begin
      win_id_s = sticky_id_r;
    end else begin
      win_id_s = scan_id_s;
    end
  end

  // Next-state and next-output logic for the window/grant FSM.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    grant_id_s  = grant_id_r;
    busy_s      = busy_r;
    abort_s     = 1'b0;
    rr_s        = rr_r;
    sticky_s    = sticky_r;
    sticky_id_s = sticky_id_r;
    cnt_s       = cnt_r;
    case (state_r)
      ST_CLOSED: begin
        grant_s = '0;
        busy_s  = 1'b0;
        if (win_open_s) begin
          state_s = ST_ARB;
        end else begin
          state_s = ST_CLOSED;
        end
      end
      ST_ARB: begin
        if (!win_open_s) begin
          state_s = ST_CLOSED;
        end else if (any_req_s) begin
          state_s    = ST_BUSY;
          grant_s    = ONE_C << win_id_s;
          grant_id_s = win_id_s;
          busy_s     = 1'b1;
          cnt_s      = '0;
        end else begin
          state_s = ST_ARB;
        end
      end
      ST_BUSY: begin
        cnt_s = cnt_r + CW'(1);
        if (release_s) begin
          state_s  = ST_ARB;
          grant_s  = '0;
          busy_s   = 1'b0;
          rr_s     = next_id_s;
          sticky_s = '0;
        end else if (!win_open_s) begin
          // Revoked by the guard band: keep rr so the victim resumes first.
          state_s     = ST_CLOSED;
          grant_s     = '0;
          busy_s      = 1'b0;
          abort_s     = 1'b1;
          sticky_s    = grant_r;
          sticky_id_s = grant_id_r;
        end else if (cnt_r == JOB_LAST_C) begin
          state_s  = ST_ARB;
          grant_s  = '0;
          busy_s   = 1'b0;
          abort_s  = 1'b1;
          rr_s     = next_id_s;
          sticky_s = '0;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_CLOSED;
        grant_s = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_CLOSED;
      grant_r     <= '0;
      grant_id_r  <= 3'd0;
      busy_r      <= 1'b0;
      abort_r     <= 1'b0;
      rr_r        <= 3'd0;
      sticky_r    <= '0;
      sticky_id_r <= 3'd0;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      grant_id_r  <= grant_id_s;
      busy_r      <= busy_s;
      abort_r     <= abort_s;
      rr_r        <= rr_s;
      sticky_r    <= sticky_s;
      sticky_id_r <= sticky_id_s;
      cnt_r       <= cnt_s;
    end
  end

  // Line/frame strobes and the frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_cnt_r   <= 8'd0;
    end else begin
      line_start_r  <= (bus.hpos == H_MAX_C);
      frame_start_r <= (bus.hpos == H_MAX_C) && (bus.vpos == V_MAX_C);
      if ((bus.hpos == H_MAX_C) && (bus.vpos == V_MAX_C)) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_id    = grant_id_r;
  assign bus.busy        = busy_r;
  assign bus.abort       = abort_r;
  assign bus.line_start  = line_start_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_cnt   = frame_cnt_r;
endmodule

// File: tb/tb_blank_slot_scheduler.sv
// Directed bench for blank_slot_scheduler: grants, fairness, guard/timeout
// aborts, sticky priority, strobes and asynchronous reset.
module tb_blank_slot_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cnt_a, cnt_b, last_c, gap_c;

  blank_slot_scheduler_if #(.NREQ(4)) bus ();

  blank_slot_scheduler #(.NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    bus.hpos = 10'd0;
    bus.vpos = 10'd0;
    bus.req  = 4'd0;
    bus.done = 4'd0;
    rst_n    = 1'b0;
    tick;
    rst_n    = 1'b1;
    tick;
  endtask

  initial begin
    bus.hpos = 10'd0;
    bus.vpos = 10'd0;
    bus.req  = 4'd0;
    bus.done = 4'd0;
    tick;
    tick;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_abort", 32'(bus.abort), 32'd0);
    chk("rst_strobes", 32'({bus.line_start, bus.frame_start}), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);

    // Sync generator parked at 0/0 is visible region: no grant.
    rst_n   = 1'b1;
    bus.req = 4'b0001;
    tick;
    tick;
    chk("oor_closed", 32'(bus.grant), 32'd0);

    // Basic grant: CLOSED -> ARB -> grant.
    bus.hpos = 10'd640;
    bus.vpos = 10'd10;
    tick;
    chk("arb_latency", 32'(bus.grant), 32'd0);
    tick;
    chk("basic_grant", 32'(bus.grant), 32'b0001);
    chk("basic_busy", 32'(bus.busy), 32'd1);
    chk("basic_id", 32'(bus.grant_id), 32'd0);
    repeat (4) tick;
    bus.done = 4'b0001;
    tick;
    bus.done = 4'b0000;
    chk("basic_release", 32'({bus.grant, bus.busy}), 32'd0);
    bus.req = 4'b0011;
    tick;
    chk("rr_after_done", 32'(bus.grant), 32'b0010);
    bus.req = 4'b0000;
    tick;
    chk("release_by_req", 32'(bus.grant), 32'd0);

    // Round-robin fairness in vblank.
    do_reset;
    bus.vpos = 10'd500;
    bus.req  = 4'b1111;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", 32'(bus.grant), 32'(1 << (i % 4)));
      chk("rr_id", 32'(bus.grant_id), 32'(i % 4));
      tick;
      tick;
      bus.done = 4'(1 << (i % 4));
      tick;
      bus.done = 4'b0000;
      chk("rr_idle", 32'(bus.grant), 32'd0);
      tick;
    end
    bus.req = 4'b0000;
    tick;

    // Guard abort near line end, then sticky priority on the next line.
    do_reset;
    bus.vpos = 10'd10;
    bus.hpos = 10'd785;
    bus.req  = 4'b0100;
    tick;
    bus.hpos = 10'd786;
    tick;
    chk("guard_grant", 32'(bus.grant), 32'b0100);
    cnt_a = 0;
    for (int h = 787; h <= 791; h++) begin
      bus.hpos = 10'(h);
      tick;
      if (bus.grant != 4'b0100) cnt_a++;
    end
    chk("guard_hold_to_791", 32'(cnt_a), 32'd0);
    bus.hpos = 10'd792;
    tick;
    chk("guard_revoke", 32'({bus.grant, bus.busy}), 32'd0);
    chk("guard_abort", 32'(bus.abort), 32'd1);
    bus.hpos = 10'd793;
    tick;
    chk("guard_abort_pulse", 32'(bus.abort), 32'd0);
    bus.vpos = 10'd11;
    bus.hpos = 10'd640;
    bus.req  = 4'b0110;
    tick;
    bus.hpos = 10'd641;
    tick;
    chk("sticky_win", 32'(bus.grant), 32'b0100);
    bus.req = 4'b0000;
    tick;

    // Visible region: no grants across the whole active line.
    bus.vpos = 10'd100;
    bus.req  = 4'b1111;
    cnt_a = 0;
    for (int h = 0; h < 640; h++) begin
      bus.hpos = 10'(h);
      tick;
      if (bus.grant != 4'b0000) cnt_a++;
    end
    chk("visible_no_grant", 32'(cnt_a), 32'd0);
    bus.hpos = 10'd640;
    tick;
    bus.hpos = 10'd641;
    tick;
    chk("rr_after_sticky", 32'(bus.grant), 32'b1000);
    bus.hpos = 10'd792;
    bus.done = 4'b1000;
    tick;
    bus.done = 4'b0000;
    chk("done_beats_close", 32'({bus.grant, bus.abort}), 32'd0);
    bus.hpos = 10'd640;
    tick;
    chk("rr_after_close_done", 32'(bus.grant), 32'b0001);
    bus.req = 4'b0000;
    tick;

    // Timeout after MAX_JOB busy cycles.
    do_reset;
    bus.vpos = 10'd500;
    bus.req  = 4'b0100;
    tick;
    tick;
    chk("timeout_grant", 32'(bus.grant), 32'b0100);
    cnt_a = 0;
    repeat (63) begin
      tick;
      if (bus.grant != 4'b0100) cnt_a++;
    end
    chk("timeout_hold_64", 32'(cnt_a), 32'd0);
    tick;
    chk("timeout_revoke", 32'({bus.grant, bus.busy}), 32'd0);
    chk("timeout_abort", 32'(bus.abort), 32'd1);
    bus.req = 4'b1100;
    tick;
    chk("timeout_rr_next", 32'(bus.grant), 32'b1000);
    chk("timeout_abort_pulse", 32'(bus.abort), 32'd0);
    bus.req = 4'b0000;
    tick;

    // Line strobe spacing with a free-running hpos.
    do_reset;
    cnt_b  = 0;
    last_c = -1;
    gap_c  = 0;
    for (int c = 0; c < 1600; c++) begin
      bus.hpos = 10'(c % 800);
      tick;
      if (bus.line_start) begin
        cnt_b++;
        if (last_c >= 0) gap_c = c - last_c;
        last_c = c;
      end
    end
    chk("line_pulses", 32'(cnt_b), 32'd2);
    chk("line_period", 32'(gap_c), 32'd800);
    chk("no_frame_yet", 32'(bus.frame_cnt), 32'd0);

    // Frame strobe and counter wrap.
    bus.hpos = 10'd799;
    bus.vpos = 10'd523;
    tick;
    chk("no_frame_523", 32'(bus.frame_start), 32'd0);
    bus.vpos = 10'd524;
    tick;
    chk("frame_start", 32'({bus.frame_start, bus.line_start}), 32'b11);
    chk("frame_cnt_1", 32'(bus.frame_cnt), 32'd1);
    bus.hpos = 10'd0;
    tick;
    chk("frame_pulse", 32'(bus.frame_start), 32'd0);
    repeat (254) begin
      bus.hpos = 10'd799;
      tick;
      bus.hpos = 10'd0;
      tick;
    end
    chk("frame_cnt_255", 32'(bus.frame_cnt), 32'd255);
    bus.hpos = 10'd799;
    tick;
    chk("frame_wrap", 32'({bus.frame_start, bus.frame_cnt}), 32'h100);
    tick;
    chk("frame_cnt_1_again", 32'(bus.frame_cnt), 32'd1);

    // Asynchronous reset mid-grant.
    bus.hpos = 10'd0;
    bus.vpos = 10'd500;
    bus.req  = 4'b0100;
    tick;
    tick;
    tick;
    chk("pre_reset_grant", 32'({bus.grant, bus.grant_id}), 32'({4'b0100, 3'd2}));
    rst_n = 1'b0;
    #1;
    chk("async_grant", 32'({bus.grant, bus.grant_id, bus.busy}), 32'd0);
    chk("async_abort", 32'(bus.abort), 32'd0);
    chk("async_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
